// File: rtl/router_input_port.sv
// -----------------------------------------------------------------------------
// router_input_port
//
// Purpose:
//   Input stage for one direction of a 2D mesh router. Incoming single-flit
//   packets are buffered in a small FIFO. The head flit gets a dimension-ordered
//   (XY) route, which is offered to the switch allocator as a one-hot request.
//   A grant from the allocator pops the head flit.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_flit    in   [63:0] incoming flit; dest X = [63 -: X_W], dest Y below it
//   in_valid   in   upstream flit valid
//   in_ready   out  FIFO can accept a flit (occupancy != DEPTH)
//   out_flit   out  [63:0] head flit, 64'h0 when empty
//   out_req    out  [4:0] one-hot route request {L,W,E,S,N}, 0 when empty
//   out_grant  in   allocator grant, pops the head flit
//   occupancy  out  [$clog2(DEPTH+1)-1:0] number of buffered flits
//   flit_count out  [31:0] popped-flit counter (only with INPORT_STATS_EN)
//
// Configuration:
//   `define INPORT_STATS_EN adds the flit_count output and its counter.
// -----------------------------------------------------------------------------
module router_input_port #(
  parameter int DEPTH = 4,
  parameter int X_W   = 4,
  parameter int Y_W   = 4,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  in_flit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [63:0]                  out_flit,
  output logic [4:0]                   out_req,
  input  logic                         out_grant,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef INPORT_STATS_EN
  ,
  output logic [31:0]                  flit_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  localparam logic [4:0] REQ_N = 5'b00001;
  localparam logic [4:0] REQ_S = 5'b00010;
  localparam logic [4:0] REQ_E = 5'b00100;
  localparam logic [4:0] REQ_W = 5'b01000;
  localparam logic [4:0] REQ_L = 5'b10000;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             full, empty;
  logic             push, pop;
  logic [63:0]      head;
  logic [X_W-1:0]   dx;
  logic [Y_W-1:0]   dy;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  // Readiness looks only at fullness, so a full FIFO refuses a flit even
  // when the head is being granted in the same cycle.
  assign push = in_valid && !full;
  assign pop  = out_grant && !empty;

  assign in_ready  = !full;
  assign occupancy = occ_q;

  // Next-state for pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is data only; its contents are meaningless while empty, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_flit = empty ? 64'h0 : head;

  assign dx = head[63 -: X_W];
  assign dy = head[63-X_W -: Y_W];

  // XY routing: resolve X first, then Y, then eject locally.
  always_comb begin
    out_req = 5'b00000;
    if (!empty) begin
      if (dx > X_W'(MY_X))      out_req = REQ_E;
      else if (dx < X_W'(MY_X)) out_req = REQ_W;
      else if (dy > Y_W'(MY_Y)) out_req = REQ_N;
      else if (dy < Y_W'(MY_Y)) out_req = REQ_S;
      else                      out_req = REQ_L;
    end
  end

`ifdef INPORT_STATS_EN
  logic [31:0] flit_count_q, flit_count_d;

  // Counts successful pops; wraps naturally at 32 bits.
  always_comb begin
    flit_count_d = flit_count_q;
    if (pop) flit_count_d = flit_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flit_count_q <= '0;
    else       flit_count_q <= flit_count_d;
  end

  assign flit_count = flit_count_q;
`endif

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;

  localparam int DEPTH = 4;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_flit;
  logic [4:0]  out_req;
  logic        out_grant;
  logic [2:0]  occupancy;
`ifdef INPORT_STATS_EN
  logic [31:0] flit_count;
`endif

  router_input_port #(
    .DEPTH(DEPTH), .X_W(4), .Y_W(4), .MY_X(MY_X), .MY_Y(MY_Y)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_req   (out_req),
    .out_grant (out_grant),
    .occupancy (occupancy)
`ifdef INPORT_STATS_EN
    ,
    .flit_count(flit_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: flits the FIFO is expected to hold, oldest first.
  logic [63:0] exp_q[$];
  logic [31:0] exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference XY route written from the routing rules.
  function automatic logic [4:0] route(input logic [63:0] f);
    int x, y;
    x = int'(f[63:60]);
    y = int'(f[59:56]);
    if (x > MY_X) return 5'b00100;
    if (x < MY_X) return 5'b01000;
    if (y > MY_Y) return 5'b00001;
    if (y < MY_Y) return 5'b00010;
    return 5'b10000;
  endfunction

  function automatic logic [63:0] mk(input int x, input int y, input logic [55:0] low);
    logic [3:0] xx, yy;
    xx = 4'(x);
    yy = 4'(y);
    return {xx, yy, low};
  endfunction

  // Reference model: updates the expected contents at each clock edge.
  initial begin
    bit do_push, do_pop;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        exp_cnt = 0;
      end else begin
        do_pop  = out_grant && (exp_q.size() != 0);
        do_push = in_valid && (exp_q.size() != DEPTH);
        if (do_pop) begin
          void'(exp_q.pop_front());
          exp_cnt++;
        end
        if (do_push) exp_q.push_back(in_flit);
      end
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() == 0) begin
        check("empty_req", 64'(out_req), 64'h0);
        check("empty_flit", out_flit, 64'h0);
      end else begin
        check("head_flit", out_flit, exp_q[0]);
        check("head_req", 64'(out_req), 64'(route(exp_q[0])));
      end
`ifdef INPORT_STATS_EN
      check("flit_count", 64'(flit_count), 64'(exp_cnt));
`endif
    end
  end

  // Apply inputs for one cycle; returns just after the following edge.
  task automatic drive(input logic v, input logic [63:0] f, input logic g);
    in_valid  = v;
    in_flit   = f;
    out_grant = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    reset = 1'b1; in_valid = 1'b0; in_flit = '0; out_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(in_ready), 64'h1);
    check("rst_req", 64'(out_req), 64'h0);
    check("rst_flit", out_flit, 64'h0);
    check("rst_occ", 64'(occupancy), 64'h0);
    reset = 1'b0;
    drive(0, '0, 0);
    drive(0, '0, 0);

    // Single flit eastbound, then granted.
    drive(1, 64'h3100_0000_0000_00AA, 0);
    check("e_req", 64'(out_req), 64'h04);
    check("e_flit", out_flit, 64'h3100_0000_0000_00AA);
    drive(0, '0, 1);
    check("e_pop_req", 64'(out_req), 64'h0);
    check("e_pop_occ", 64'(occupancy), 64'h0);

    // Fill with W, N, S, L heads.
    drive(1, mk(0, 1, 56'h11), 0);
    drive(1, mk(1, 2, 56'h22), 0);
    drive(1, mk(1, 0, 56'h33), 0);
    drive(1, mk(1, 1, 56'h44), 0);
    check("full_occ", 64'(occupancy), 64'h4);
    check("full_ready", 64'(in_ready), 64'h0);
    check("full_req_w", 64'(out_req), 64'h08);
    drive(1, mk(2, 2, 56'h55), 0);
    check("drop_occ", 64'(occupancy), 64'h4);
    check("drop_head", out_flit, mk(0, 1, 56'h11));

    // Full with push and grant together: pop only.
    drive(1, mk(2, 2, 56'h66), 1);
    check("fullpg_occ", 64'(occupancy), 64'h3);
    check("fullpg_ready", 64'(in_ready), 64'h1);
    check("req_n", 64'(out_req), 64'h01);
    drive(0, '0, 1);
    check("req_s", 64'(out_req), 64'h02);
    drive(1, mk(3, 0, 56'h77), 1);
    check("pg_occ", 64'(occupancy), 64'h2);
    check("req_l", 64'(out_req), 64'h10);
    drive(0, '0, 1);
    check("tail_flit", out_flit, mk(3, 0, 56'h77));
    drive(0, '0, 1);

    // Streaming push/pop across pointer wrap.
    drive(1, mk(0, 0, 56'h100), 0);
    for (int i = 0; i < 10; i++)
      drive(1, mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 56'(i + 'h200)), 1);
    check("stream_occ", 64'(occupancy), 64'h1);
    drive(0, '0, 1);

    // Grant while empty.
    drive(0, '0, 1);
    drive(0, '0, 1);
    check("ue_occ", 64'(occupancy), 64'h0);
    check("ue_flit", out_flit, 64'h0);

    // Asynchronous reset mid-stream.
    drive(1, mk(2, 1, 56'h1), 0);
    drive(1, mk(0, 1, 56'h2), 0);
    drive(1, mk(1, 3, 56'h3), 0);
    check("pre_rst_occ", 64'(occupancy), 64'h3);
    reset = 1'b1;
    #1;
    check("arst_occ", 64'(occupancy), 64'h0);
    check("arst_req", 64'(out_req), 64'h0);
    check("arst_ready", 64'(in_ready), 64'h1);
    drive(0, '0, 0);
    reset = 1'b0;
    drive(0, '0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      f = {$urandom, $urandom};
      f[63:60] = 4'($urandom_range(0, 2));
      f[59:56] = 4'($urandom_range(0, 2));
      drive(1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 99) < 45));
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(0, '0, 1);
    check("drain_occ", 64'(occupancy), 64'h0);

`ifdef INPORT_STATS_EN
    reset = 1'b1;
    drive(0, '0, 0);
    reset = 1'b0;
    drive(1, mk(0, 0, 56'h1), 0);
    for (int i = 0; i < 5; i++) drive(1, mk(2, 2, 56'(i)), 1);
    drive(0, '0, 1);
    check("stats6", 64'(flit_count), 64'd6);
    @(negedge clk);
    force dut.flit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.flit_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    drive(1, mk(1, 1, 56'h9), 0);
    drive(0, '0, 1);
    check("stats_wrap", 64'(flit_count), 64'd0);
    reset = 1'b1;
    #1;
    check("stats_rst", 64'(flit_count), 64'd0);
    drive(0, '0, 0);
    reset = 1'b0;
    drive(0, '0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- Per-direction input stage of a mesh router: buffers incoming 64-bit single-flit packets in a FIFO.
- Computes a dimension-ordered (XY) route for the head flit.
- Presents a one-hot output-port request to the switch allocator; the allocator's sel_* one-hot vectors drive the 5x5 crossbar downstream.
- Five instances per router (N, S, E, W, L) feed the crossbar's *_data_in inputs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- X_W, 4, width of destination-X field.
- Y_W, 4, width of destination-Y field.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_flit  input  64  incoming flit; dest X in [63:64-X_W], dest Y in the next Y_W bits below.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  FIFO can accept a flit.
- out_flit  output  64  head flit to crossbar; 64'h0 when empty.
- out_req  output  5  one-hot route request; bit0=N, bit1=S, bit2=E, bit3=W, bit4=L; 5'b0 when empty.
- out_grant  input  1  allocator grant; pops the head flit.
- occupancy  output  $clog2(DEPTH+1)  entries held.

Behaviour:
- Reset (async, active-high): wr_ptr, rd_ptr and occupancy clear to 0. Outputs during and after reset: in_ready=1, out_req=0, out_flit=0, occupancy=0. Storage array is not reset.
- Push: at posedge when in_valid && in_ready. Writes mem[wr_ptr]; wr_ptr increments mod DEPTH, wrapping naturally from DEPTH-1 to 0.
- in_ready = (occupancy != DEPTH). Combinational; does not depend on out_grant. A full FIFO never accepts, even if a pop occurs the same cycle.
- Pop: at posedge when out_grant && occupancy != 0. rd_ptr increments mod DEPTH. out_grant while empty is ignored: no pointer change, no underflow.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; both pointers advance.
- Latency: a flit pushed at edge t appears on out_flit/out_req after edge t (one cycle) if the FIFO was empty. Otherwise it appears once the preceding flits are popped.
- out_flit = mem[rd_ptr] when non-empty. Combinational read of the registered head.
- Route computation, combinational from the head flit (dx = dest X, dy = dest Y, unsigned compare):
  - dx > MY_X -> E.
  - dx < MY_X -> W.
  - else dy > MY_Y -> N.
  - else dy < MY_Y -> S.
  - else -> L.
  - Exactly one bit is set when non-empty.
- out_req and out_flit stay stable until granted; the allocator relies on this for round-robin fairness.
- Reset asserted mid-operation: all buffered flits are discarded immediately (asynchronous); outputs return to reset values in the same cycle.

Optional Feature:
- Macro INPORT_STATS_EN.
- Defined: adds output port flit_count (32-bit). It increments by 1 on every successful pop, wraps from 32'hFFFF_FFFF to 0, and clears on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan (DEPTH=4, X_W=Y_W=4, MY_X=1, MY_Y=1):
1. Reset, then idle -> in_ready=1, out_req=5'b00000, out_flit=64'h0, occupancy=0.
2. Push 64'h3100_0000_0000_00AA -> next cycle out_req=5'b00100 (E), out_flit=64'h3100_0000_0000_00AA. Pulse out_grant -> next cycle empty, out_req=0.
3. Push one flit each of dest (0,1), (1,2), (1,0), (1,1) with no grant:
   - Heads in order give out_req 5'b01000 (W), 5'b00001 (N), 5'b00010 (S), 5'b10000 (L).
   - After 4 pushes: occupancy=4, in_ready=0.
   - A 5th push with in_valid=1 is dropped: occupancy stays 4, head unchanged.
4. Full FIFO with in_valid=1 and out_grant=1 in the same cycle -> pop only: occupancy=3, then in_ready=1.
   - Occupancy 2 with push and grant together -> occupancy stays 2, FIFO order preserved.
   - Run 10 push/pop cycles -> pointers wrap; data order intact.
5. out_grant=1 while empty -> occupancy stays 0, no X on outputs.
   - Reset asserted mid-stream with occupancy=3 -> occupancy=0 and out_req=0 before the next clk edge.
6. With INPORT_STATS_EN: 6 grants -> flit_count=6.
   - Preload the counter to 32'hFFFF_FFFF via force; one more grant -> 0.
   - Reset -> flit_count=0.
